if_fetch_stage: RTL and testbench

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

---
 rtl/if_pkg.sv | 18 +
 rtl/if_instr_fifo.sv | 58 +++++
 rtl/if_fetch_stage.sv | 115 +++++++++++
 tb/tb_if_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// rtl/if_pkg.sv - shared widths, NOP encoding and fetch FSM state type
package if_pkg;

    localparam int PC_W_DEF    = 8;
    localparam int INSTR_W_DEF = 16;

    // Bubble presented to decode whenever the instruction FIFO is empty.
    localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = '0;

    // IDLE: nothing outstanding, WAIT: one read in flight,
    // DISCARD: one read in flight whose data must be dropped (branch overtook it).
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_instr_fifo.sv
// rtl/if_instr_fifo.sv - two-entry FIFO of {pc, instr} with flush and occupancy count
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push_i       write wdata_i (accepted on a full FIFO only with a same-cycle pop)
//   pop_i        drop the head entry (ignored when empty)
//   flush_i      discard all entries; overrides push and pop
//   wdata_i      entry to write
//   head_o       oldest entry (meaningless when count_o == 0)
//   count_o      occupancy, 0..2
module if_instr_fifo #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         flush_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_pop;
    logic         do_push;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush_i) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) wr_ptr_q <= ~wr_ptr_q;
            if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    // Payload needs no reset: it is only observed while count_q says it is valid.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch stage: PC, single-outstanding imem reads, 2-deep buffer to decode
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   hazard_detected               decode stalls this cycle; head is held
//   branch_taken, branch_target   flush and redirect fetch
//   imem_req, imem_addr           one-cycle read request to instruction memory
//   imem_rvalid, imem_rdata       in-order read response
//   instr_ID, pc_ID, valid_ID     FIFO head presented to decode (NOP / 0 when empty)
module if_fetch_stage
    import if_pkg::*;
#(
    parameter int              PC_W     = PC_W_DEF,
    parameter int              INSTR_W  = INSTR_W_DEF,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               hazard_detected,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_ID,
    output logic [PC_W-1:0]    pc_ID,
    output logic               valid_ID
);

    localparam int ENT_W = PC_W + INSTR_W;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_addr_q, req_addr_d;

    logic [1:0]       fifo_count;
    logic [ENT_W-1:0] fifo_head;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_empty;

    assign fifo_empty = (fifo_count == 2'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        fifo_push  = 1'b0;

        // Only IDLE has nothing in flight, so the state alone covers the
        // outstanding term of the occupancy limit. rst_n gating keeps the
        // request low while reset is held.
        imem_req = rst_n && (state_q == ST_IDLE) && (fifo_count < 2'd2) && !branch_taken;

        if (imem_req) begin
            pc_d       = pc_q + PC_W'(1);
            req_addr_d = pc_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A response here has no matching request (e.g. one issued before reset).
                if (imem_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    state_d   = ST_IDLE;
                    fifo_push = !branch_taken;
                end else if (branch_taken) begin
                    state_d = ST_DISCARD;
                end
            end
            ST_DISCARD: begin
                if (imem_rvalid) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (branch_taken) pc_d = branch_target;
    end

    assign fifo_pop = !fifo_empty && !hazard_detected && !branch_taken;

    if_instr_fifo #(
        .W (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (branch_taken),
        .wdata_i ({req_addr_q, imem_rdata}),
        .head_o  (fifo_head),
        .count_o (fifo_count)
    );

    assign imem_addr = pc_q;
    assign valid_ID  = !fifo_empty;
    assign pc_ID     = fifo_empty ? '0 : fifo_head[ENT_W-1:INSTR_W];
    assign instr_ID  = fifo_empty ? INSTR_W'(NOP_INSTR) : fifo_head[INSTR_W-1:0];

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - randomized self-checking bench for if_fetch_stage
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        hazard_detected = 1'b0;
    logic        branch_taken = 1'b0;
    logic [7:0]  branch_target = 8'h00;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [15:0] imem_rdata = 16'h0000;
    logic [15:0] instr_ID;
    logic [7:0]  pc_ID;
    logic        valid_ID;

    if_fetch_stage #(
        .PC_W     (8),
        .INSTR_W  (16),
        .RESET_PC (8'h00)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .hazard_detected (hazard_detected),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .instr_ID        (instr_ID),
        .pc_ID           (pc_ID),
        .valid_ID        (valid_ID)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [15:0] ins;
    } ent_t;

    // Reference model: queue of buffered instructions, fetch PC, in-flight request.
    ent_t       mq[$];
    logic [7:0] m_pc;
    logic [7:0] m_raddr;
    bit         m_out;
    bit         m_disc;

    // Memory responder.
    bit         mem_pend;
    int         mem_cnt;
    logic [7:0] mem_addr;
    int         lat;
    bit         inj_rv;

    // Values sampled in the last cycle.
    logic        s_req;
    logic        s_valid;
    logic [7:0]  s_addr;
    logic [7:0]  s_pc;
    logic [15:0] s_instr;

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc    = 8'h00;
        m_raddr = 8'h00;
        m_out   = 1'b0;
        m_disc  = 1'b0;
    endtask

    // One clock cycle: drive inputs just after posedge, check at negedge, advance model.
    task automatic cycle(input bit hz, input bit br, input logic [7:0] tgt);
        bit   e_req;
        ent_t e;
        hazard_detected = hz;
        branch_taken    = br;
        branch_target   = tgt;
        imem_rvalid     = 1'b0;
        imem_rdata      = 16'($urandom);
        if (inj_rv) begin
            imem_rvalid = 1'b1;
            inj_rv      = 1'b0;
        end else if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = {8'h00, mem_addr} + 16'h0100;
                mem_pend    = 1'b0;
            end
        end
        @(negedge clk);
        s_req   = imem_req;
        s_addr  = imem_addr;
        s_valid = valid_ID;
        s_pc    = pc_ID;
        s_instr = instr_ID;
        e_req = !m_out && (mq.size() < 2) && !br;
        check("imem_req", s_req, e_req);
        if (e_req) check("imem_addr", s_addr, m_pc);
        check("valid_ID", s_valid, mq.size() > 0);
        check("pc_ID", s_pc, mq.size() > 0 ? mq[0].pc : 8'h00);
        check("instr_ID", s_instr, mq.size() > 0 ? mq[0].ins : 16'h0000);
        if (s_req) begin
            check("mem_overlap", mem_pend, 1'b0);
            mem_pend = 1'b1;
            mem_addr = s_addr;
            mem_cnt  = (lat > 0) ? lat : $urandom_range(1, 3);
        end
        if (br) begin
            mq.delete();
            m_pc = tgt;
            if (m_out && imem_rvalid) begin
                m_out  = 1'b0;
                m_disc = 1'b0;
            end else if (m_out) begin
                m_disc = 1'b1;
            end
        end else begin
            if (mq.size() > 0 && !hz) void'(mq.pop_front());
            if (m_out && imem_rvalid) begin
                if (!m_disc) begin
                    e.pc  = m_raddr;
                    e.ins = imem_rdata;
                    mq.push_back(e);
                end
                m_out  = 1'b0;
                m_disc = 1'b0;
            end
            if (e_req) begin
                m_out   = 1'b1;
                m_raddr = m_pc;
                m_pc    = m_pc + 8'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // what: 0 = wait for a request, 1 = wait for valid_ID
    task automatic wait_for(input int what, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            if ((what == 0) ? s_req : s_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        bit         ok;
        logic [7:0] seen[2];
        int         nseen;

        lat      = 1;
        inj_rv   = 1'b0;
        mem_pend = 1'b0;
        model_reset();

        #2;
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_valid_ID", valid_ID, 1'b0);
        check("rst_pc_ID", pc_ID, 8'h00);
        check("rst_instr_ID", instr_ID, 16'h0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First fetch and best-case latency
        cycle(1'b0, 1'b0, 8'h00);
        check("first_req", s_req, 1'b1);
        check("first_addr", s_addr, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 8'h00);
        check("first_valid", s_valid, 1'b1);
        check("first_pc", s_pc, 8'h00);
        check("first_instr", s_instr, 16'h0100);

        // Load-use stall with pc_ID = 5
        for (int i = 0; i < 40 && !(mq.size() > 0 && mq[0].pc == 8'h05); i++)
            cycle(1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 8'h00);
            check("stall_pc", s_pc, 8'h05);
            check("stall_instr", s_instr, 16'h0105);
        end
        check("stall_req_stopped", s_req, 1'b0);
        wait_for(0, ok);
        check("stall_resume", ok, 1'b1);

        // Branch while a slow request is outstanding
        lat = 3;
        wait_for(0, ok);
        cycle(1'b0, 1'b1, 8'h40);
        wait_for(0, ok);
        check("br_out_req_seen", ok, 1'b1);
        check("br_out_addr", s_addr, 8'h40);
        wait_for(1, ok);
        check("br_out_valid_seen", ok, 1'b1);
        check("br_out_pc", s_pc, 8'h40);

        // Branch coinciding with rvalid and hazard
        lat = 1;
        wait_for(0, ok);
        cycle(1'b1, 1'b1, 8'h40);
        cycle(1'b0, 1'b0, 8'h00);
        check("br_rv_valid", s_valid, 1'b0);
        check("br_rv_req", s_req, 1'b1);
        check("br_rv_addr", s_addr, 8'h40);

        // PC wrap-around
        cycle(1'b0, 1'b1, 8'hFF);
        nseen = 0;
        for (int i = 0; i < 20 && nseen < 2; i++) begin
            cycle(1'b0, 1'b0, 8'h00);
            if (s_valid) begin
                seen[nseen] = s_pc;
                nseen++;
            end
        end
        check("wrap_count", nseen, 2);
        check("wrap_pc0", seen[0], 8'hFF);
        check("wrap_pc1", seen[1], 8'h00);

        // Reset with a request outstanding; stale responses during and after reset
        lat = 3;
        wait_for(0, ok);
        #2;
        rst_n           = 1'b0;
        hazard_detected = 1'b0;
        branch_taken    = 1'b0;
        #1;
        check("mid_rst_req", imem_req, 1'b0);
        check("mid_rst_valid", valid_ID, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hDEAD;
        @(posedge clk);
        #1;
        check("rst_rv_valid", valid_ID, 1'b0);
        imem_rvalid = 1'b0;
        model_reset();
        mem_pend = 1'b0;
        rst_n    = 1'b1;
        inj_rv   = 1'b1;
        cycle(1'b0, 1'b0, 8'h00);
        check("post_rst_req", s_req, 1'b1);
        check("post_rst_addr", s_addr, 8'h00);
        check("post_rst_valid", s_valid, 1'b0);
        wait_for(1, ok);
        check("post_rst_valid_seen", ok, 1'b1);
        check("post_rst_pc", s_pc, 8'h00);

        // Randomized traffic with random memory latency
        lat = 0;
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
